mems_spi_slave: RTL and testbench
=================================

Name: mems_spi_slave

Overview:
- SPI responder for the MEMS link.
- Receives fixed-width frames from an SPI master: sck idles low, MOSI is sampled on the sck rising edge and MISO changes on the sck falling edge, MSB first, framed by active-low chip select.
- Runs entirely in the system clk domain: all pins are oversampled through synchronizers.
- Returns a preloaded response word on MISO and hands the received word to the core with a one-cycle strobe.

Parameters:
- DATA_W, 24, frame length in bits (shift register, tx/rx word width).
- SYNC_STAGES, 2, flip-flop depth of each pin synchronizer (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 8x the sck frequency.
- rst_n  in  1  asynchronous, active-low reset.
- sck  in  1  SPI clock pin (asynchronous).
- mosi  in  1  SPI data from master (asynchronous).
- cs_n  in  1  chip select, active low (asynchronous).
- miso  out  1  SPI data to master.
- miso_oe  out  1  output enable for the MISO pad driver; 1 while selected.
- tx_data  in  DATA_W  next response word.
- tx_load  in  1  strobe: capture tx_data into the response buffer.
- rx_data  out  DATA_W  last complete received word.
- new_data  out  1  one-cycle pulse; rx_data updated this cycle.
- aborted  out  1  one-cycle pulse; frame ended early (cs_n rose before DATA_W bits).
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset, asynchronous on rst_n low:
  - All outputs 0; state IDLE; tx_buf 0; bit counter 0.
  - Synchronizers reset to sck=0, mosi=0, cs_n=1.
- Synchronization and edge detection:
  - Each pin passes through SYNC_STAGES flops, then one extra flop for edge detection.
  - Rising, falling and select events are single-cycle, derived from the synchronized samples only.
- Response buffer: tx_buf captures tx_data on tx_load in any state. The buffer is copied to the shift register only at frame start.
- State IDLE:
  - miso=0, miso_oe=0, busy=0.
  - On a synchronized cs_n falling event:
    - Load the shift register from tx_buf. If tx_load is high in the same cycle, load tx_data instead (bypass).
    - Clear the bit counter and go to ACTIVE.
    - Drive miso = response MSB and miso_oe=1 from the next cycle onward.
- State ACTIVE (busy=1):
  - sck rising event: shift the synchronized mosi into the LSB; increment the bit counter.
  - sck falling event: shift the next response bit out on miso. Ignore a falling event before the first rising event of the frame.
  - When the counter reaches DATA_W on a rising event:
    - Copy the received word to rx_data.
    - Pulse new_data in the following cycle.
    - Go to DONE.
  - cs_n rising event before DATA_W bits: pulse aborted, leave rx_data unchanged, go to IDLE.
  - If cs_n rises in the same cycle as the final rising event, the frame completes: new_data pulses and aborted does not.
- State DONE (busy=1):
  - Ignore all further sck edges; miso holds its last value.
  - A cs_n rising event moves to IDLE.
- Latency:
  - new_data is high exactly SYNC_STAGES+2 clk cycles after the DATA_W-th sck rising edge at the pin.
  - miso updates SYNC_STAGES+2 cycles after the sck falling edge.
- Glitches:
  - sck edges while cs_n is high are ignored.
  - A cs_n falling event seen while in DONE or ACTIVE is impossible by construction; cs_n must rise first.
- Back-to-back frames:
  - A new frame may start the cycle after the return to IDLE.
  - tx_buf is reused if not reloaded.
- Bit counter width: clog2(DATA_W+1). There is no wrap; the counter cannot pass DATA_W.

Decomposition:
- Shared package mems_spi_pkg holds:
  - the MEMS_SPI_DATA_W constant (24);
  - the state encoding (IDLE, ACTIVE, DONE);
  - the SCK mode definition, so master and slave use one source.
- Sub-module: mems_sync_edge, a SYNC_STAGES-deep synchronizer plus rise/fall detector, instantiated three times (sck, mosi, cs_n; edges unused for mosi).

Test Plan:
- Full frame: tx_load 0xA5C3F0, master sends 0x123456 at clk/8 → MISO bits equal 0xA5C3F0 MSB first; rx_data=0x123456; new_data exactly one pulse, SYNC_STAGES+2 cycles after the 24th rising sck.
- Abort: cs_n rises after 10 bits of 0xFFFFFF → aborted pulses once, new_data stays 0, rx_data keeps its prior value, busy drops, next full frame 0x000001 is received correctly.
- Extra clocks: 30 sck pulses in one frame carrying 0xDEADBE plus 6 bits → rx_data=0xDEADBE; the 6 extra edges are ignored; one new_data.
- Bypass: tx_load with 0x00FF00 in the same cycle as the synchronized cs_n fall, with tx_buf previously 0x111111 → MISO returns 0x00FF00.
- Reset mid-frame: rst_n low after 12 bits → all outputs 0 immediately and asynchronously; after release, a full frame 0x654321 is received with no stale bits.
- Noise while idle: sck toggles 20 times with cs_n high → no busy, no new_data, miso_oe=0.

Source files
------------

// File: rtl/mems_spi_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the MEMS SPI link: frame width, responder states and
// the SCK mode, so master and slave agree on one source.
package mems_spi_pkg;

  localparam int unsigned MEMS_SPI_DATA_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic cpol;  // idle level of sck
    logic cpha;  // 0: sample on leading edge, shift on trailing edge
  } sck_mode_t;

  localparam sck_mode_t MEMS_SCK_MODE = '{cpol: 1'b0, cpha: 1'b0};

endpackage

// File: rtl/mems_sync_edge.sv
`timescale 1ns/1ps
// Multi-flop synchronizer for one asynchronous pin, followed by a delay flop
// that yields single-cycle rise/fall events from the synchronized level.
module mems_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      dly_q  <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~dly_q;
  assign fall  = ~level & dly_q;

endmodule

// File: rtl/mems_spi_slave.sv
`timescale 1ns/1ps
// SPI responder for the MEMS link, fully in the clk domain: pins are
// oversampled, a preloaded word is returned on MISO, the received word strobed out.
module mems_spi_slave
  import mems_spi_pkg::*;
#(
  parameter int unsigned DATA_W      = MEMS_SPI_DATA_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              mosi,
  input  logic              cs_n,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic [DATA_W-1:0] rx_data,
  output logic              new_data,
  output logic              aborted,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic sck_level_unused, sck_rise, sck_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;
  logic cs_level_unused, cs_rise, cs_fall;
  logic lead_edge, trail_edge;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] tx_buf, tx_shreg, rx_shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              complete_q;
  logic              frame_start, do_sample, do_shift, frame_done, abort;

  mems_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .din(sck),
    .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );

  mems_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(mosi),
    .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  mems_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din(cs_n),
    .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
  );

  assign lead_edge  = MEMS_SCK_MODE.cpol ? sck_fall : sck_rise;
  assign trail_edge = MEMS_SCK_MODE.cpol ? sck_rise : sck_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    do_sample   = 1'b0;
    do_shift    = 1'b0;
    frame_done  = 1'b0;
    abort       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          frame_start = 1'b1;
          state_d     = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        do_sample  = lead_edge;
        // A trailing edge before the first sample would drop the MSB.
        do_shift   = trail_edge && (bit_cnt != '0);
        frame_done = lead_edge && (bit_cnt == CNT_W'(DATA_W - 1));
        // Completion wins over a coincident deselect; skip DONE since the
        // cs_n rise event has already been consumed.
        if (frame_done) begin
          state_d = cs_rise ? ST_IDLE : ST_DONE;
        end else if (cs_rise) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (cs_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_buf     <= '0;
      tx_shreg   <= '0;
      rx_shreg   <= '0;
      bit_cnt    <= '0;
      rx_data    <= '0;
      complete_q <= 1'b0;
      new_data   <= 1'b0;
      aborted    <= 1'b0;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
    end else begin
      if (tx_load) tx_buf <= tx_data;
      if (frame_start) begin
        tx_shreg <= tx_load ? tx_data : tx_buf;
        rx_shreg <= '0;
        bit_cnt  <= '0;
      end
      if (do_sample) begin
        rx_shreg <= {rx_shreg[DATA_W-2:0], mosi_s};
        bit_cnt  <= bit_cnt + CNT_W'(1);
      end
      if (do_shift) tx_shreg <= {tx_shreg[DATA_W-2:0], 1'b0};
      if (frame_done) rx_data <= {rx_shreg[DATA_W-2:0], mosi_s};
      complete_q <= frame_done;
      new_data   <= complete_q;
      aborted    <= abort;
      // Registered pad outputs add the final cycle of MISO latency.
      miso_oe    <= busy;
      miso       <= busy & tx_shreg[DATA_W-1];
    end
  end

endmodule

// File: tb/tb_mems_spi_slave.sv
`timescale 1ns/1ps
// Directed bench for mems_spi_slave: table of frames plus hand-written
// reset, abort and idle-noise sequences.
module tb_mems_spi_slave;

  logic        clk = 1'b0;
  logic        rst_n, sck, mosi, cs_n, tx_load;
  logic [23:0] tx_data;
  logic        miso, miso_oe, new_data, aborted, busy;
  logic [23:0] rx_data;

  int checks = 0;
  int failures = 0;
  int nd_cnt = 0, ab_cnt = 0, busy_seen = 0, oe_seen = 0;

  always #5 clk = ~clk;

  mems_spi_slave #(.DATA_W(24), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .mosi(mosi), .cs_n(cs_n),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
    .rx_data(rx_data), .new_data(new_data), .aborted(aborted), .busy(busy)
  );

  always @(negedge clk) begin
    if (new_data) nd_cnt++;
    if (aborted)  ab_cnt++;
    if (busy)     busy_seen++;
    if (miso_oe)  oe_seen++;
  end

  typedef struct {
    logic        do_load;
    logic [23:0] tx_word;
    logic        bypass;
    logic [23:0] byp_word;
    logic [31:0] mosi_bits;
    int          nbits;
    logic [23:0] exp_rx;
    logic [23:0] exp_miso;
    int          exp_nd;
    int          exp_ab;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [23:0] w);
    tx_data = w;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    @(negedge clk);
  endtask

  // Master at clk/8: each sck half period is four clk cycles, pins move on negedge clk.
  task automatic run_frame(input logic [31:0] bits, input int nbits, input logic byp,
                           input logic [23:0] byp_word, input logic do_end,
                           output logic [23:0] cap);
    cap  = '0;
    cs_n = 1'b0;
    if (byp) begin
      repeat (2) @(negedge clk);
      tx_data = byp_word;
      tx_load = 1'b1;
      @(negedge clk);
      tx_load = 1'b0;
      repeat (3) @(negedge clk);
    end else begin
      repeat (6) @(negedge clk);
    end
    for (int i = 0; i < nbits; i++) begin
      mosi = bits[nbits-1-i];
      repeat (4) @(negedge clk);
      if (i < 24) cap[23-i] = miso;
      sck = 1'b1;
      if (i == 23) begin
        repeat (3) @(negedge clk);
        check("nd_early", {31'd0, new_data}, 32'd0);
        @(negedge clk);
        check("nd_latency", {31'd0, new_data}, 32'd1);
      end else begin
        repeat (4) @(negedge clk);
      end
      sck = 1'b0;
    end
    repeat (6) @(negedge clk);
    if (do_end) begin
      cs_n = 1'b1;
      repeat (6) @(negedge clk);
    end
  endtask

  initial begin
    logic [23:0] cap;
    int nd0, ab0;

    vecs[0] = '{1'b1, 24'hA5C3F0, 1'b0, 24'h0, 32'h00123456, 24, 24'h123456, 24'hA5C3F0, 1, 0};
    vecs[1] = '{1'b0, 24'h0,      1'b0, 24'h0, 32'h000003FF, 10, 24'h123456, 24'h0,      0, 1};
    vecs[2] = '{1'b1, 24'h0F0F0F, 1'b0, 24'h0, 32'h00000001, 24, 24'h000001, 24'h0F0F0F, 1, 0};
    vecs[3] = '{1'b1, 24'h5A5A5A, 1'b0, 24'h0, {2'b00, 24'hDEADBE, 6'b101011}, 30,
                24'hDEADBE, 24'h5A5A5A, 1, 0};
    vecs[4] = '{1'b1, 24'h111111, 1'b1, 24'h00FF00, 32'h00ABCDEF, 24, 24'hABCDEF, 24'h00FF00, 1, 0};
    vecs[5] = '{1'b0, 24'h0,      1'b0, 24'h0, 32'h0000C0DE, 24, 24'h00C0DE, 24'h00FF00, 1, 0};

    rst_n = 1'b0; sck = 1'b0; mosi = 1'b0; cs_n = 1'b1; tx_load = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    check("rst_rx_data", {8'd0, rx_data}, 32'd0);
    check("rst_outputs", {26'd0, miso, miso_oe, new_data, aborted, busy, 1'b0}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].do_load) preload(vecs[v].tx_word);
      nd0 = nd_cnt;
      ab0 = ab_cnt;
      run_frame(vecs[v].mosi_bits, vecs[v].nbits, vecs[v].bypass, vecs[v].byp_word, 1'b1, cap);
      check($sformatf("v%0d_rx_data", v), {8'd0, rx_data}, {8'd0, vecs[v].exp_rx});
      if (vecs[v].nbits >= 24)
        check($sformatf("v%0d_miso", v), {8'd0, cap}, {8'd0, vecs[v].exp_miso});
      check($sformatf("v%0d_new_data_pulses", v), nd_cnt - nd0, vecs[v].exp_nd);
      check($sformatf("v%0d_aborted_pulses", v), ab_cnt - ab0, vecs[v].exp_ab);
      check($sformatf("v%0d_idle_after", v), {30'd0, busy, miso_oe}, 32'd0);
    end

    // Idle noise: sck toggles with cs_n high must not start anything.
    nd0 = nd_cnt;
    busy_seen = 0;
    oe_seen = 0;
    for (int i = 0; i < 20; i++) begin
      mosi = i[0];
      sck = ~sck;
      repeat (4) @(negedge clk);
    end
    sck = 1'b0;
    repeat (6) @(negedge clk);
    check("noise_busy", busy_seen, 0);
    check("noise_miso_oe", oe_seen, 0);
    check("noise_new_data", nd_cnt - nd0, 0);

    // Asynchronous reset in the middle of a frame.
    run_frame(32'h00000FFF, 12, 1'b0, 24'h0, 1'b0, cap);
    check("midframe_busy", {31'd0, busy}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_rx_data", {8'd0, rx_data}, 32'd0);
    check("async_rst_outputs", {27'd0, miso, miso_oe, new_data, aborted, busy}, 32'd0);
    @(negedge clk);
    cs_n = 1'b1;
    sck = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    nd0 = nd_cnt;
    run_frame(32'h00654321, 24, 1'b0, 24'h0, 1'b1, cap);
    check("post_rst_rx_data", {8'd0, rx_data}, 32'h00654321);
    check("post_rst_miso", {8'd0, cap}, 32'd0);
    check("post_rst_new_data_pulses", nd_cnt - nd0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
